// File: rtl/disp_scan_if.sv
// Display scan bus: digit sources, overlay handshake, blink mask and scan outputs.
interface disp_scan_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] main_digits;
  logic [4*N_DIGITS-1:0] info_digits;
  logic                  info_req;
  logic                  info_ack;
  logic [N_DIGITS-1:0]   blink_mask;
  logic [10:0]           num;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_start;

  // Source side: supplies digits and requests, observes the scan outputs.
  modport master (
    output main_digits, info_digits, info_req, blink_mask,
    input  info_ack, num, an, frame_start
  );

  // Controller side.
  modport slave (
    input  main_digits, info_digits, info_req, blink_mask,
    output info_ack, num, an, frame_start
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned overlay
// arbitration, per-digit blinking and anti-ghost blanking at each slot start.
module disp_scan_ctrl #(
  parameter int unsigned N_DIGITS  = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 200,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic         clk,
  input  logic         rst,
  disp_scan_if.slave   bus
);

  localparam int unsigned CNT_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned IDX_W = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned NUM_W = 11;

  localparam logic [NUM_W-1:0] NUM_DASH  = NUM_W'(11);
  localparam logic [NUM_W-1:0] NUM_BLANK = NUM_W'(15);

  typedef enum logic {ST_MAIN, ST_INFO} state_e;

  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                hidden_q,  hidden_d;
  state_e              state_q,   state_d;
  logic [N_DIGITS-1:0] an_q,      an_d;
  logic [NUM_W-1:0]    num_q,     num_d;
  logic                ack_q,     ack_d;
  logic                fs_q,      fs_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [4*N_DIGITS-1:0] src;
  logic [3:0]            nib;
  logic                  mask_bit;
  logic [NUM_W-1:0]      dec;

  // Next-state for counters, arbitration and the registered scan outputs.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    blk_cnt_d = blk_cnt_q + BLK_W'(1);
    hidden_d  = hidden_q;
    state_d   = state_q;
    an_d      = '1;
    num_d     = NUM_BLANK;
    nib       = 4'hF;
    mask_bit  = 1'b0;
    dec       = NUM_BLANK;

    slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));

    if (slot_end) begin
      cnt_d = '0;
      idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    end

    if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      hidden_d  = ~hidden_q;
    end

    // Source switches only on a frame boundary so a frame is never mixed.
    if (frame_end) begin
      state_d = bus.info_req ? ST_INFO : ST_MAIN;
    end

    src = (state_d == ST_INFO) ? bus.info_digits : bus.main_digits;

    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib      = src[4*i +: 4];
        mask_bit = bus.blink_mask[i];
      end
    end

    if (nib <= 4'd9) begin
      dec = NUM_W'(nib);
    end else if (nib == 4'hA) begin
      dec = NUM_DASH;
    end else begin
      dec = NUM_BLANK;
    end

    // Outside the blanking window exactly one anode is driven low.
    if (cnt_d >= CNT_W'(BLANK_CYC)) begin
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          an_d[i] = 1'b0;
        end
      end
      num_d = (hidden_d && mask_bit) ? NUM_BLANK : dec;
    end

    ack_d = (state_d == ST_INFO);
    fs_d  = frame_end;
  end

  // State and output registers, async reset to idle/blank display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
      hidden_q  <= 1'b0;
      state_q   <= ST_MAIN;
      an_q      <= '1;
      num_q     <= NUM_BLANK;
      ack_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
      hidden_q  <= hidden_d;
      state_q   <= state_d;
      an_q      <= an_d;
      num_q     <= num_d;
      ack_q     <= ack_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.num         = num_q;
  assign bus.info_ack    = ack_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: a time-based reference model predicts each
// cycle's outputs into a queue, which is popped and checked after the edge.
module tb_disp_scan_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;
  localparam int unsigned BD = 64;
  localparam int unsigned FRAME = SD * N;

  typedef struct {
    logic [N-1:0] an;
    logic [10:0]  num;
    logic         ack;
    logic         fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  disp_scan_if #(.N_DIGITS(N)) bus ();

  disp_scan_ctrl #(
    .N_DIGITS (N),
    .SCAN_DIV (SD),
    .BLANK_CYC(BC),
    .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   t      = 0;
  logic m_ack  = 1'b0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, want);
    end
  endtask

  function automatic logic [10:0] decode(input logic [3:0] n);
    case (n)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9: return {7'd0, n};
      4'hA:                         return 11'd11;
      default:                      return 11'd15;
    endcase
  endfunction

  // Predict next cycle from current inputs, advance one clock, compare.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      exp_t o;
      int tn, cnt, idx;
      logic hidden;
      logic [4*N-1:0] src;
      logic [3:0] nib;
      tn     = t + 1;
      cnt    = tn % SD;
      idx    = (tn / SD) % N;
      hidden = ((tn / BD) % 2) == 1;
      e.ack  = ((tn % FRAME) == 0) ? bus.info_req : m_ack;
      e.fs   = ((tn % FRAME) == 0);
      src    = e.ack ? bus.info_digits : bus.main_digits;
      nib    = 4'(src >> (4 * idx));
      if (cnt < BC) begin
        e.an  = '1;
        e.num = 11'd15;
      end else begin
        e.an  = ~(N'(1) << idx);
        e.num = (hidden && bus.blink_mask[idx]) ? 11'd15 : decode(nib);
      end
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      t     = tn;
      o     = sb.pop_front();
      m_ack = o.ack;
      check("an",          32'(bus.an),          32'(o.an));
      check("num",         32'(bus.num),         32'(o.num));
      check("info_ack",    32'(bus.info_ack),    32'(o.ack));
      check("frame_start", 32'(bus.frame_start), 32'(o.fs));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_an"},  32'(bus.an),          32'hFF);
    check({tag, "_num"}, 32'(bus.num),         32'd15);
    check({tag, "_ack"}, 32'(bus.info_ack),    32'd0);
    check({tag, "_fs"},  32'(bus.frame_start), 32'd0);
  endtask

  initial begin
    bus.main_digits = 32'h76543210;
    bus.info_digits = 32'h99999999;
    bus.info_req    = 1'b0;
    bus.blink_mask  = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    t = 0;
    m_ack = 1'b0;

    // Plain scan of digits 0..7 over two frames.
    tick(64);

    // Dash on digit 3, blank code on digit 4.
    bus.main_digits = 32'h765CA210;
    tick(32);

    // Overlay requested mid-frame; granted only at the next boundary.
    tick(10);
    bus.info_req = 1'b1;
    tick(30);
    check("granted_at_boundary", 32'(bus.info_ack), 32'd1);
    tick(10);
    bus.info_req = 1'b0;
    tick(30);
    check("released_at_boundary", 32'(bus.info_ack), 32'd0);

    // Short pulse between boundaries is ignored.
    tick(10);
    bus.info_req = 1'b1;
    tick(1);
    bus.info_req = 1'b0;
    tick(40);
    check("pulse_ignored", 32'(bus.info_ack), 32'd0);

    // Blink digit 0 across several blink phases.
    bus.blink_mask  = 8'h01;
    bus.main_digits = 32'h76543210;
    tick(200);

    // Enter overlay, then reset mid-frame.
    bus.info_req = 1'b1;
    tick(FRAME - (t % FRAME) + 18);
    check("in_info_before_reset", 32'(bus.info_ack), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    @(negedge clk);
    check_reset_state("held_reset");
    bus.info_req = 1'b0;
    rst = 1'b0;
    t = 0;
    m_ack = 1'b0;
    tick(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Sequences one digit at a time into the shared seven-segment decoder and drives the active-low anode select.
- Arbitrates the display between the main (time) source and an info/alarm overlay requester.
- Applies per-digit blinking and anti-ghost blanking.

Parameters:
- N_DIGITS, 8, number of digits scanned; anode and mask width.
- SCAN_DIV, 100000, clk cycles per digit slot (≥ BLANK_CYC+2).
- BLANK_CYC, 200, cycles at slot start with all anodes off.
- BLINK_DIV, 25000000, clk cycles per blink phase toggle.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- main_digits  in  4*N_DIGITS  main source nibbles; digit i = bits [4i+3:4i].
- info_digits  in  4*N_DIGITS  overlay source nibbles, same packing.
- info_req  in  1  overlay request, level.
- info_ack  out  1  overlay currently displayed.
- blink_mask  in  N_DIGITS  1 = digit i blinks.
- num  out  11  decoder code (zero-extended): 0-9 digit, 11 dash, 15 blank.
- an  out  N_DIGITS  anode select, active-low, one-hot-low or all ones.
- frame_start  out  1  one-cycle pulse when digit 0 slot begins.

Behaviour:
- Reset (async, rst=1): slot counter=0, idx=0, blink phase=visible, an=all ones, num=15, info_ack=0, frame_start=0. All outputs are registered.
- Slot counter runs 0..SCAN_DIV-1 and wraps. At the terminal count, idx advances (N_DIGITS-1 wraps to 0).
- Output timing: an and num reflect the new idx one cycle after the terminal count, i.e. registered from the next-state idx. frame_start pulses in the same cycle that idx becomes 0.
- Blanking: while slot counter < BLANK_CYC, an=all ones and num=15. Otherwise an has only bit idx low.
- Nibble mapping from the selected source, digit idx:
  - 0-9 → num=nibble.
  - 4'hA → num=11 (dash).
  - 4'hB-4'hF → num=15 (blank).
- Blink: a counter toggles the phase every BLINK_DIV cycles. When the phase is hidden and blink_mask[idx]=1, num=15; an is unaffected.
- Arbitration FSM (states MAIN, INFO):
  - MAIN → INFO only at a frame boundary (terminal count of digit N_DIGITS-1) with info_req=1.
  - INFO → MAIN only at a frame boundary with info_req=0.
  - info_ack=1 exactly while in INFO, changing in the same cycle idx wraps to 0. A frame is therefore never mixed between sources.
- info_req is sampled only at the frame boundary. Pulses shorter than a frame that fall between boundaries are ignored. Once granted, the overlay is held for ≥1 full frame.
- Input changes to digit vectors or mask mid-slot take effect at the next registered update (within one cycle).
- Reset mid-scan or mid-overlay returns everything to reset values immediately. First frame after reset release: idx=0, MAIN.

Test Plan (SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=64, N_DIGITS=8):
1. Reset, main_digits=32'h76543210, mask=0 → per slot: 1 cycle an=FF/num=15, then 3 cycles an=FE/num=0, then FD/1 … 7F/7. Digit 0 repeats after 32 cycles; frame_start pulses every 32 cycles.
2. Digit 3 nibble=4'hA, digit 4 nibble=4'hC → num=11 while an=F7; num=15 while an=EF.
3. info_req raised mid-frame (cycle 10) with info_digits=32'h99999999 → info_ack rises with the next idx=0 (cycle 32). num=9 for the whole frame; no 9 appears before that.
4. info_req dropped at cycle 40 → info_ack falls at cycle 64. Main digits resume from digit 0; a 1-cycle info_req pulse at cycle 70 yields no grant.
5. blink_mask=8'h01 → digit 0 shows num=0 for 64 cycles and num=15 for the next 64. The an pattern is unchanged; other digits are unaffected.
6. rst pulsed at cycle 50 while in INFO → an=FF, num=15, info_ack=0 asynchronously. After release, scanning restarts at digit 0 from MAIN.
